// File: rtl/pipe_stage_ctrl_pkg.sv
// pipe_stage_ctrl_pkg: shared types for the LC-3b pipeline sequencer.
package pipe_stage_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN} lc3b_pipe_state;
endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// pipe_stage_ctrl_if: hazard flags in, stage load strobes/valids/cache strobes out.
interface pipe_stage_ctrl_if #(parameter int CNT_W = 16);
  logic icache_resp;
  logic dmem_req;
  logic dcache_resp;
  logic load_use;
  logic br_taken;
  logic load_pc;
  logic load_ifid;
  logic load_idex;
  logic load_exmem;
  logic load_memwb;
  logic valid_id;
  logic valid_ex;
  logic valid_mem;
  logic valid_wb;
  logic icache_read;
  logic dcache_strobe;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    input  icache_resp, dmem_req, dcache_resp, load_use, br_taken,
    output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    output valid_id, valid_ex, valid_mem, valid_wb,
    output icache_read, dcache_strobe, stall_cycles
  );
  modport slave (
    output icache_resp, dmem_req, dcache_resp, load_use, br_taken,
    input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    input  valid_id, valid_ex, valid_mem, valid_wb,
    input  icache_read, dcache_strobe, stall_cycles
  );
endinterface

// File: rtl/pipe_stage_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with async active-high reset.
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: LC-3b pipeline load/valid/cache-strobe sequencer.
// Stall performance counter built only when PIPE_STALL_PERF_EN is defined.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(parameter int CNT_W = 16) (
  input logic clk,
  input logic reset,
  pipe_stage_ctrl_if.master p
);
  lc3b_pipe_state state;
  logic dstall, flush, luse, fmiss, drain, adv;
  always_comb begin
    drain = state == DRAIN;
    dstall = p.valid_mem & p.dmem_req & ~p.dcache_resp;
    flush = p.valid_mem & p.br_taken & ~dstall;
    luse = p.load_use & p.valid_id & p.valid_ex & ~dstall & ~flush;
    fmiss = ~dstall & ~flush & ~luse & ~drain & ~p.icache_resp;
    adv = ~reset & ~dstall;
    p.load_pc = adv & ~luse & (flush | p.icache_resp);
    p.load_ifid = adv & ~luse;
    p.load_idex = adv;
    p.load_exmem = adv;
    p.load_memwb = adv;
    p.icache_read = ~reset & (state != MEM_WAIT);
    p.dcache_strobe = ~reset & ~drain & p.valid_mem & p.dmem_req;
  end
  // A fetch landing during DRAIN belongs to the squashed path, so ID gets a bubble.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      p.valid_id <= 1'b0;
      p.valid_ex <= 1'b0;
      p.valid_mem <= 1'b0;
      p.valid_wb <= 1'b0;
    end else begin
      state <= dstall ? MEM_WAIT : ((flush | drain) & ~p.icache_resp) ? DRAIN : RUN;
      if (!dstall) begin
        p.valid_id <= (flush | drain) ? 1'b0 : luse ? p.valid_id : p.icache_resp;
        p.valid_ex <= ~(flush | luse) & p.valid_id;
        p.valid_mem <= ~flush & p.valid_ex;
        p.valid_wb <= p.valid_mem;
      end
    end
`ifdef PIPE_STALL_PERF_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(dstall | luse | fmiss | drain),
    .count(p.stall_cycles)
  );
`else
  assign p.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: scoreboard bench with a stage-occupancy reference model.
module tb_pipe_stage_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pipe_stage_ctrl_if #(.CNT_W(W)) p ();
  pipe_stage_ctrl #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .p(p));
  typedef struct packed {
    logic [4:0]   ld;
    logic [3:0]   vl;
    logic [1:0]   st;
    logic [W-1:0] sc;
  } exp_t;
  exp_t q[$];
  exp_t me, ma;
  int total = 0, bad = 0;
  // v[0]=ID .. v[3]=WB occupancy; waiting/draining describe the pipeline's mode.
  bit [3:0] v;
  bit waiting, draining;
  int stalls;
  function automatic exp_t actual();
    return {p.load_pc, p.load_ifid, p.load_idex, p.load_exmem, p.load_memwb,
            p.valid_wb, p.valid_mem, p.valid_ex, p.valid_id,
            p.icache_read, p.dcache_strobe, p.stall_cycles};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    v = '0;
    waiting = 0;
    draining = 0;
    stalls = 0;
  endtask
  task automatic cyc(input bit ic, input bit dm, input bit dr, input bit lu, input bit br);
    exp_t e;
    bit ds, fl, lh;
    @(posedge clk);
    #1;
    p.icache_resp = ic;
    p.dmem_req = dm;
    p.dcache_resp = dr;
    p.load_use = lu;
    p.br_taken = br;
    ds = v[2] && dm && !dr;
    fl = !ds && v[2] && br;
    lh = !ds && !fl && lu && v[0] && v[1];
    e.vl = v;
    e.st = {!waiting, !draining && v[2] && dm};
`ifdef PIPE_STALL_PERF_EN
    e.sc = (stalls >= (1 << W) - 1) ? '1 : stalls[W-1:0];
`else
    e.sc = '0;
`endif
    if (ds || draining || lh || (!fl && !ic)) stalls++;
    if (ds) e.ld = 5'b00000;
    else if (fl) begin
      e.ld = 5'b11111;
      v = 4'b1000;
    end else if (draining) begin
      e.ld = {ic, 4'b1111};
      v = {v[2:0], 1'b0};
    end else if (lh) begin
      e.ld = 5'b00111;
      v = {v[2:1], 1'b0, v[0]};
    end else begin
      e.ld = {ic, 4'b1111};
      v = {v[2:0], ic};
    end
    draining = !ds && (fl || draining) && !ic;
    waiting = ds;
    q.push_back(e);
  endtask
  task automatic chk_reset_state(input string n);
    ma = actual();
    chk({n, "_loads"}, 32'(ma.ld), 0);
    chk({n, "_valids"}, 32'(ma.vl), 0);
    chk({n, "_strobes"}, 32'(ma.st), 0);
    chk({n, "_stall"}, 32'(ma.sc), 0);
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      me = q.pop_front();
      ma = actual();
      chk("loads", 32'(ma.ld), 32'(me.ld));
      chk("valids", 32'(ma.vl), 32'(me.vl));
      chk("strobes", 32'(ma.st), 32'(me.st));
      chk("stall_cycles", 32'(ma.sc), 32'(me.sc));
    end
  initial begin
    {p.icache_resp, p.dmem_req, p.dcache_resp, p.load_use, p.br_taken} = '0;
    model_reset();
    #2;
    p.dmem_req = 1'b1;
    chk_reset_state("por");
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (5) cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1);
    repeat (4) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    #6;
    reset = 1'b1;
    #1;
    chk_reset_state("mid_wait");
    @(posedge clk);
    #5;
    reset = 1'b0;
    model_reset();
    {p.icache_resp, p.dmem_req, p.dcache_resp, p.load_use, p.br_taken} = '0;
    repeat (4) cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
